// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and width bounds for the serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
// Ports: a, b, carry_in (operand bits and incoming carry);
//        q (sum bit), carry_out (outgoing carry).
module full_adder (
    input  logic carry_in,
    input  logic a,
    input  logic b,
    output logic q,
    output logic carry_out
);

    logic half_sum;

    assign half_sum  = a ^ b;
    assign q         = half_sum ^ carry_in;
    assign carry_out = (a & b) | (carry_in & half_sum);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder around one full_adder cell
// Ports: clk, rst (sync, active-high);
//        in_valid/in_ready with a, b, carry_in (operand handshake);
//        out_valid/out_ready with sum, carry_out (result handshake);
//        busy (operation in RUN or DONE).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);

    // One extra count value keeps WIDTH=1 at a legal, non-zero counter width.
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_r;
    logic [CNT_W-1:0] bit_cnt;
    logic             fa_q;
    logic             fa_carry_out;

    full_adder u_full_adder (
        .carry_in  (carry_r),
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .q         (fa_q),
        .carry_out (fa_carry_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_r <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_r <= carry_in;
                        bit_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // New sum bit enters at the MSB; after WIDTH shifts the
                    // first (LSB) result bit has reached position 0.
                    sum_sh  <= (sum_sh >> 1) | (WIDTH'(fa_q) << (WIDTH - 1));
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_r <= fa_carry_out;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags depend on the state register only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_sh;
    assign carry_out = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;
    import serial_adder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic       i8_in_valid, i8_in_ready, i8_ci, i8_out_valid, i8_out_ready, i8_co, i8_busy;
    logic [7:0] i8_a, i8_b, i8_sum;
    logic       i3_in_valid, i3_in_ready, i3_ci, i3_out_valid, i3_out_ready, i3_co, i3_busy;
    logic [2:0] i3_a, i3_b, i3_sum;
    logic       i1_in_valid, i1_in_ready, i1_ci, i1_out_valid, i1_out_ready, i1_co, i1_busy;
    logic [0:0] i1_a, i1_b, i1_sum;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(i8_in_valid), .in_ready(i8_in_ready),
        .a(i8_a), .b(i8_b), .carry_in(i8_ci), .out_valid(i8_out_valid),
        .out_ready(i8_out_ready), .sum(i8_sum), .carry_out(i8_co), .busy(i8_busy)
    );

    serial_adder #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(i3_in_valid), .in_ready(i3_in_ready),
        .a(i3_a), .b(i3_b), .carry_in(i3_ci), .out_valid(i3_out_valid),
        .out_ready(i3_out_ready), .sum(i3_sum), .carry_out(i3_co), .busy(i3_busy)
    );

    serial_adder #(.WIDTH(WIDTH_MIN)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(i1_in_valid), .in_ready(i1_in_ready),
        .a(i1_a), .b(i1_b), .carry_in(i1_ci), .out_valid(i1_out_valid),
        .out_ready(i1_out_ready), .sum(i1_sum), .carry_out(i1_co), .busy(i1_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation. hold: cycles out_ready stays low in DONE.
    // pulse_at: RUN cycle index at which a stray AA/55 pair is pulsed (-1 none).
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic [7:0] es, input logic eco,
                       input int hold, input int pulse_at);
        int lat;
        @(negedge clk);
        i8_out_ready = (hold == 0);
        i8_in_valid  = 1'b1;
        i8_a         = av;
        i8_b         = bv;
        i8_ci        = ci;
        chk("w8_in_ready_idle", i8_in_ready, 1'b1);
        @(posedge clk);
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (i8_out_valid || lat >= 40) break;
            i8_in_valid = (lat == pulse_at);
            if (lat == pulse_at) begin
                i8_a = 8'hAA;
                i8_b = 8'h55;
                chk("w8_in_ready_run", i8_in_ready, 1'b0);
            end
            @(posedge clk);
            lat++;
        end
        i8_in_valid = 1'b0;
        chk("w8_latency", lat, 8);
        for (int k = 0; k < hold; k++) begin
            chk("w8_hold_valid", i8_out_valid, 1'b1);
            chk("w8_hold_sum", i8_sum, es);
            chk("w8_hold_co", i8_co, eco);
            @(posedge clk);
            @(negedge clk);
        end
        i8_out_ready = 1'b1;
        chk("w8_sum", i8_sum, es);
        chk("w8_co", i8_co, eco);
        chk("w8_out_valid", i8_out_valid, 1'b1);
        @(posedge clk);
        @(negedge clk);
        i8_out_ready = 1'b0;
        chk("w8_valid_after_hs", i8_out_valid, 1'b0);
        chk("w8_ready_after_hs", i8_in_ready, 1'b1);
        chk("w8_sum_kept_idle", i8_sum, es);
        @(posedge clk);
        @(negedge clk);
        chk("w8_not_busy", i8_busy, 1'b0);
    endtask

    // Back-to-back operation on the WIDTH=1 or WIDTH=3 instance, out_ready held high.
    task automatic op_small(input int w, input int av, input int bv, input int ci);
        int lat;
        logic [3:0] obs;
        logic [3:0] exp;
        logic ov;
        @(negedge clk);
        if (w == 1) begin
            i1_in_valid = 1'b1; i1_a = av[0:0]; i1_b = bv[0:0]; i1_ci = ci[0];
            chk("w1_in_ready", i1_in_ready, 1'b1);
        end else begin
            i3_in_valid = 1'b1; i3_a = av[2:0]; i3_b = bv[2:0]; i3_ci = ci[0];
            chk("w3_in_ready", i3_in_ready, 1'b1);
        end
        @(posedge clk);
        lat = 0;
        while (1) begin
            @(negedge clk);
            i1_in_valid = 1'b0;
            i3_in_valid = 1'b0;
            ov = (w == 1) ? i1_out_valid : i3_out_valid;
            if (ov || lat >= 20) break;
            @(posedge clk);
            lat++;
        end
        exp = 4'(av + bv + ci);
        obs = (w == 1) ? {2'b00, i1_co, i1_sum} : {i3_co, i3_sum};
        chk((w == 1) ? "w1_latency" : "w3_latency", lat, w);
        chk((w == 1) ? "w1_result" : "w3_result", obs, exp);
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        i8_in_valid = 0; i8_a = 0; i8_b = 0; i8_ci = 0; i8_out_ready = 0;
        i3_in_valid = 0; i3_a = 0; i3_b = 0; i3_ci = 0; i3_out_ready = 1;
        i1_in_valid = 0; i1_a = 0; i1_b = 0; i1_ci = 0; i1_out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", i8_in_ready, 1'b1);
        chk("rst_out_valid", i8_out_valid, 1'b0);
        chk("rst_busy", i8_busy, 1'b0);
        chk("rst_sum", i8_sum, 8'h00);
        chk("rst_co", i8_co, 1'b0);
        chk("rst_w3_ready", i3_in_ready, 1'b1);
        chk("rst_w1_ready", i1_in_ready, 1'b1);

        op8(8'h5A, 8'hC3, 1'b0, 8'h1D, 1'b1, 0, -1);
        op8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0, -1);
        op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, -1);
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 5, -1);
        op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0, 2);
        op8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 2, -1);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        i8_in_valid = 1'b1; i8_a = 8'hF0; i8_b = 8'h0F; i8_ci = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i8_in_valid = 1'b0;
        chk("mid_busy", i8_busy, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", i8_in_ready, 1'b1);
        chk("mid_rst_valid", i8_out_valid, 1'b0);
        chk("mid_rst_sum", i8_sum, 8'h00);
        chk("mid_rst_co", i8_co, 1'b0);
        chk("mid_rst_busy", i8_busy, 1'b0);
        i8_out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (i8_out_valid) seen++;
        end
        chk("mid_rst_no_result", seen, 0);
        i8_out_ready = 1'b0;

        for (int av = 0; av < 2; av++)
            for (int bv = 0; bv < 2; bv++)
                for (int ci = 0; ci < 2; ci++)
                    op_small(1, av, bv, ci);
        for (int av = 0; av < 8; av++)
            for (int bv = 0; bv < 8; bv++)
                for (int ci = 0; ci < 2; ci++)
                    op_small(3, av, bv, ci);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
